rr_arbiter_1of5: RTL and testbench

Round-robin arbiter sharing one resource among 5 requesters.
- Produces a registered one-hot grant: exactly one of five, or none.
- Tracks ownership until the owner signals completion.
- Rotates priority so no requester is starved.
- Sits in front of the shared "one-of-five choice" datapath and sequences access to it.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_pick_1of5.sv | 26 ++
 rtl/rr_arbiter_1of5.sv | 137 +++++++++++++
 tb/tb_rr_arbiter_1of5.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 1-of-5 round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 5;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Successor of a requester index, wrapping 4 -> 0.
    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        return (idx >= ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick_1of5.sv
// Combinational rotating-priority search: first set req bit starting at ptr.
module rr_pick_1of5
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  pick,
    output logic             valid
);

    logic [ID_W-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid && req[idx]) begin
                pick  = idx;
                valid = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/rr_arbiter_1of5.sv
// Round-robin arbiter for 5 requesters with registered one-hot grant.
// Optional grant-length limit enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_1of5
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    state_t           state, state_n;
    logic [ID_W-1:0]  ptr, ptr_n;
    logic [N_REQ-1:0] gnt_n;
    logic [ID_W-1:0]  gnt_id_n;
    logic             busy_n;
    logic [ID_W-1:0]  pick;
    logic             pick_valid;
    logic             rel;
    logic             revoke;

    rr_pick_1of5 u_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
    logic             timeout_n;

    assign revoke = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign revoke  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Only the current owner's request line and done can end a grant.
    assign rel = done || !req[gnt_id];

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        busy_n   = busy;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_n = hold_cnt;
        timeout_n  = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_n    = N_REQ'(1) << pick;
                    gnt_id_n = pick;
                    busy_n   = 1'b1;
                    state_n  = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_n = '0;
`endif
                end else begin
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    busy_n   = 1'b0;
                end
            end
            ST_GRANT: begin
                if (rel || revoke) begin
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    busy_n   = 1'b0;
                    ptr_n    = next_idx(gnt_id);
                    state_n  = ST_GAP;
`ifdef ARB_TIMEOUT_EN
                    timeout_n = !rel;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_n = hold_cnt + 1'b1;
`endif
                end
            end
            ST_GAP: begin
                gnt_n    = '0;
                gnt_id_n = '0;
                busy_n   = 1'b0;
                state_n  = ST_IDLE;
            end
            default: begin
                gnt_n    = '0;
                gnt_id_n = '0;
                busy_n   = 1'b0;
                state_n  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gnt    <= gnt_n;
            gnt_id <= gnt_id_n;
            busy   <= busy_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_n;
            timeout  <= timeout_n;
        end
    end
`endif

endmodule

// File: tb/tb_rr_arbiter_1of5.sv
// Self-checking bench for rr_arbiter_1of5 (default build, ARB_TIMEOUT_EN undefined).
module tb_rr_arbiter_1of5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0;
    logic       done = 1'b0;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    // Reference model: current owner (-1 = none), pending gap cycle, priority pointer.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_ptr   = 0;

    logic [9:0] obs;
    logic [9:0] exp;

    always #5 clk = ~clk;

    rr_arbiter_1of5 dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    assign obs = {gnt, gnt_id, busy, timeout};

    // Expected {gnt, gnt_id, busy, timeout} for a given owner.
    function automatic logic [9:0] pack(input int owner);
        if (owner < 0) return '0;
        return {5'(1 << owner), 3'(owner), 1'b1, 1'b0};
    endfunction

    task automatic model_step(input logic [4:0] r, input logic d, input logic rs);
        if (rs) begin
            m_owner = -1;
            m_gap   = 1'b0;
            m_ptr   = 0;
        end else if (m_owner >= 0) begin
            if (d || !r[m_owner]) begin
                m_ptr   = (m_owner + 1) % 5;
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 5]) m_owner = (m_ptr + k) % 5;
            end
        end
    endtask

    // Drive inputs for one cycle, advance the model at the edge, sample 1ns later.
    task automatic cycle(input logic [4:0] r, input logic d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        model_step(r, d, rs);
        #1;
    endtask

    task automatic test_reset;
        cycle(5'b11111, 1'b1, 1'b1);
        cycle(5'b00000, 1'b0, 1'b1);
        tests++;
        if (obs !== 10'd0) begin
            fails++;
            $display("[TB] FAIL reset: got %b expected %b", obs, 10'd0);
        end
        cycle(5'b00000, 1'b0, 1'b0);
    endtask

    task automatic test_basic;
        cycle(5'b10100, 1'b0, 1'b0);
        tests++;
        if (obs !== {5'b00100, 3'd2, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL basic_first_grant: got %b expected %b", obs, {5'b00100, 3'd2, 1'b1, 1'b0});
        end
        cycle(5'b10100, 1'b1, 1'b0);
        tests++;
        if (obs !== 10'd0) begin
            fails++;
            $display("[TB] FAIL basic_release: got %b expected %b", obs, 10'd0);
        end
        cycle(5'b10100, 1'b0, 1'b0);
        tests++;
        if (obs !== 10'd0) begin
            fails++;
            $display("[TB] FAIL basic_gap: got %b expected %b", obs, 10'd0);
        end
        cycle(5'b10100, 1'b0, 1'b0);
        tests++;
        if (obs !== {5'b10000, 3'd4, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL basic_second_grant: got %b expected %b", obs, {5'b10000, 3'd4, 1'b1, 1'b0});
        end
    endtask

    task automatic test_round_robin;
        cycle(5'b00000, 1'b0, 1'b1);
        cycle(5'b11111, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (obs !== pack(k % 5)) begin
                fails++;
                $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, obs, pack(k % 5));
            end
            cycle(5'b11111, 1'b1, 1'b0);
            tests++;
            if (gnt !== 5'b00000) begin
                fails++;
                $display("[TB] FAIL rr_release_%0d: got %b expected %b", k, gnt, 5'b00000);
            end
            cycle(5'b11111, 1'b0, 1'b0);
            tests++;
            if (gnt !== 5'b00000) begin
                fails++;
                $display("[TB] FAIL rr_gap_%0d: got %b expected %b", k, gnt, 5'b00000);
            end
            cycle(5'b11111, 1'b0, 1'b0);
        end
    endtask

    task automatic test_implicit_release;
        cycle(5'b00000, 1'b0, 1'b1);
        cycle(5'b01000, 1'b0, 1'b0);
        tests++;
        if (obs !== {5'b01000, 3'd3, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL implicit_grant3: got %b expected %b", obs, {5'b01000, 3'd3, 1'b1, 1'b0});
        end
        cycle(5'b00001, 1'b0, 1'b0);
        tests++;
        if (obs !== 10'd0) begin
            fails++;
            $display("[TB] FAIL implicit_drop: got %b expected %b", obs, 10'd0);
        end
        cycle(5'b01001, 1'b0, 1'b0);
        cycle(5'b01001, 1'b0, 1'b0);
        tests++;
        if (obs !== {5'b00001, 3'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL implicit_next_wrap: got %b expected %b", obs, {5'b00001, 3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_grant;
        cycle(5'b00000, 1'b0, 1'b1);
        cycle(5'b00010, 1'b0, 1'b0);
        tests++;
        if (obs !== {5'b00010, 3'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL midrst_grant: got %b expected %b", obs, {5'b00010, 3'd1, 1'b1, 1'b0});
        end
        cycle(5'b00010, 1'b0, 1'b1);
        tests++;
        if (obs !== 10'd0) begin
            fails++;
            $display("[TB] FAIL midrst_cleared: got %b expected %b", obs, 10'd0);
        end
        cycle(5'b00110, 1'b0, 1'b0);
        tests++;
        if (obs !== {5'b00010, 3'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL midrst_ptr_zero: got %b expected %b", obs, {5'b00010, 3'd1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_done_idle;
        cycle(5'b00000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(5'b00000, 1'b1, 1'b0);
            tests++;
            if (obs !== 10'd0) begin
                fails++;
                $display("[TB] FAIL done_idle_%0d: got %b expected %b", k, obs, 10'd0);
            end
        end
        cycle(5'b00001, 1'b0, 1'b0);
        tests++;
        if (obs !== {5'b00001, 3'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL done_idle_then_grant: got %b expected %b", obs, {5'b00001, 3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_hold;
        cycle(5'b00000, 1'b0, 1'b1);
        for (int k = 0; k < 24; k++) begin
            cycle(5'b00010, 1'b0, 1'b0);
            tests++;
            if (obs !== {5'b00010, 3'd1, 1'b1, 1'b0}) begin
                fails++;
                $display("[TB] FAIL hold_%0d: got %b expected %b", k, obs, {5'b00010, 3'd1, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_random;
        logic [4:0] r;
        logic       d;
        logic [4:0] prev_gnt;
        cycle(5'b00000, 1'b0, 1'b1);
        prev_gnt = '0;
        for (int k = 0; k < 10000; k++) begin
            r = 5'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            d = ($urandom_range(0, 3) == 0);
            cycle(r, d, ($urandom_range(0, 499) == 0));
            exp = pack(m_owner);
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("[TB] FAIL random_%0d: got %b expected %b", k, obs, exp);
            end
            tests++;
            if ((prev_gnt != 0) && (gnt != 0) && (gnt != prev_gnt)) begin
                fails++;
                $display("[TB] FAIL random_adjacent_%0d: got %b after %b expected a zero cycle", k, gnt, prev_gnt);
            end
            prev_gnt = gnt;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            assert ($countones(gnt) <= 1) else $error("[TB] FAIL onehot: gnt=%b", gnt);
        end
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_implicit_release();
        test_reset_mid_grant();
        test_done_idle();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
